axis_frame_gen: RTL and testbench

- Single-clock AXI4-Stream frame generator, the transmitter that sources traffic into an AXI stream FIFO input (tdata/tvalid/tready/tlast/tuser).
- Emits a programmed number of frames with a deterministic byte pattern, programmable length and inter-frame gap, and optional tuser error marking.
- Used for bring-up traffic and bench stimulus in front of the async and sync FIFOs.

---
 rtl/axis_frame_gen.sv | 169 ++++++++++++++++
 tb/tb_axis_frame_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream frame generator with programmable length, count, gap and error marking
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_count,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic                  err_inject,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, count_q, count_d, beat_q, beat_d, fs_q, fs_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d, tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                  stop_q, stop_d, errp_q, errp_d;
  logic                  hs, last_hs, pend, run_done, first_is_last;
  logic [LEN_WIDTH-1:0]  fs_inc, last_idx, next_beat, start_len;

  always_comb begin
    hs            = tvalid_q & output_axis_tready;
    last_hs       = hs & tlast_q;
    // error flag as it stands once a consumed marking has been retired
    pend          = errp_q & ~(last_hs & tuser_q);
    fs_inc        = fs_q + LEN_WIDTH'(1);
    last_idx      = len_q - LEN_WIDTH'(1);
    next_beat     = beat_q + LEN_WIDTH'(1);
    first_is_last = (last_idx == '0);
    start_len     = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
    run_done      = stop_q | stop | ((count_q != '0) && (fs_inc == count_q));

    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    gap_d    = gap_q;
    seed_d   = seed_q;
    beat_d   = beat_q;
    fs_d     = fs_q;
    gcnt_d   = gcnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    stop_d   = stop_q;
    errp_d   = pend | err_inject;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          len_d    = start_len;
          count_d  = cfg_frame_count;
          gap_d    = cfg_gap;
          seed_d   = cfg_seed;
          fs_d     = '0;
          beat_d   = '0;
          stop_d   = stop;
          tvalid_d = 1'b1;
          tdata_d  = cfg_seed;
          tlast_d  = (start_len == LEN_WIDTH'(1));
          tuser_d  = (start_len == LEN_WIDTH'(1)) & pend;
        end
      end
      SEND: begin
        stop_d = stop_q | stop;
        if (hs && !tlast_q) begin
          beat_d  = next_beat;
          tdata_d = tdata_q + DATA_WIDTH'(1);
          tlast_d = (next_beat == last_idx);
          tuser_d = (next_beat == last_idx) & pend;
        end else if (last_hs) begin
          fs_d = fs_inc;
          if (run_done) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            stop_d   = 1'b0;
          end else if (gap_q == '0) begin
            beat_d  = '0;
            tdata_d = seed_q + DATA_WIDTH'(fs_inc);
            tlast_d = first_is_last;
            tuser_d = first_is_last & pend;
          end else begin
            state_d  = GAP;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            gcnt_d   = gap_q;
          end
        end
      end
      GAP: begin
        if (stop_q || stop) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (gcnt_q == GAP_WIDTH'(1)) begin
          state_d  = SEND;
          beat_d   = '0;
          tvalid_d = 1'b1;
          tdata_d  = seed_q + DATA_WIDTH'(fs_q);
          tlast_d  = first_is_last;
          tuser_d  = first_is_last & pend;
        end else begin
          gcnt_d = gcnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      seed_q   <= '0;
      beat_q   <= '0;
      fs_q     <= '0;
      gcnt_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      stop_q   <= 1'b0;
      errp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      seed_q   <= seed_d;
      beat_q   <= beat_d;
      fs_q     <= fs_d;
      gcnt_q   <= gcnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      stop_q   <= stop_d;
      errp_q   <= errp_d;
    end
  end

  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign output_axis_tlast  = tlast_q;
  assign output_axis_tuser  = tuser_q;
  assign busy               = (state_q != IDLE);
  assign frames_sent        = fs_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - self-checking bench for axis_frame_gen against a frame-list reference model
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, err_inject, tready;
  logic [15:0] cfg_frame_len, cfg_frame_count;
  logic [7:0]  cfg_gap, cfg_seed;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  axis_frame_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .cfg_frame_len      (cfg_frame_len),
    .cfg_frame_count    (cfg_frame_count),
    .cfg_gap            (cfg_gap),
    .cfg_seed           (cfg_seed),
    .err_inject         (err_inject),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .output_axis_tlast  (tlast),
    .output_axis_tuser  (tuser),
    .busy               (busy),
    .frames_sent        (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one run and watches it to completion; expectations come from the frame list model
  task automatic run(input int len, input int cnt, input int gap, input int seed, input int nframes,
                     input int err_frame, input int stop_frame, input bit stop_at_start, input bit rnd);
    logic [9:0] obs[$];
    int         gaps[$];
    logic [9:0] held_val = '0;
    bit         held = 0;
    bit         done = 0;
    int         idle_cyc = -1;
    int         last_hs = -1;
    int         low_run = 0;
    int         frame = 0;
    int         bidx = 0;
    int         eff = (len == 0) ? 1 : len;
    int         n, k;
    logic [9:0] exp_beat;

    @(negedge clk);
    cfg_frame_len   = 16'(len);
    cfg_frame_count = 16'(cnt);
    cfg_gap         = 8'(gap);
    cfg_seed        = 8'(seed);
    start           = 1'b1;
    stop            = stop_at_start;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; err_inject = 1'b0;
      cfg_frame_len   = 16'($urandom);
      cfg_frame_count = 16'($urandom);
      cfg_gap         = 8'($urandom);
      cfg_seed        = 8'($urandom);
      if (!busy) begin
        done = 1; idle_cyc = cyc;
        break;
      end
      if (held) check("hold", {21'b0, tvalid, tuser, tlast, tdata}, {21'b0, 1'b1, held_val});
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && bidx == 0 && frame == stop_frame) stop = 1'b1;
      if (tvalid && bidx == 0 && frame == err_frame) err_inject = 1'b1;
      if (tvalid) begin
        if (low_run > 0) gaps.push_back(low_run);
        low_run = 0;
      end else begin
        low_run++;
      end
      held = 0;
      if (tvalid && tready) begin
        obs.push_back({tuser, tlast, tdata});
        last_hs = cyc;
        if (tlast) begin frame++; bidx = 0; end
        else bidx++;
      end else if (tvalid) begin
        held = 1;
        held_val = {tuser, tlast, tdata};
      end
    end
    tready = 1'b1;

    check("run_terminated", 32'(done), 32'd1);
    check("busy_after_last", 32'(idle_cyc), 32'(last_hs + 1));
    check("beat_count", 32'(obs.size()), 32'(nframes * eff));
    for (int i = 0; i < obs.size() && i < nframes * eff; i++) begin
      n = i / eff;
      k = i % eff;
      exp_beat = {(k == eff - 1) && (n == err_frame), k == eff - 1, 8'((seed + n + k) & 255)};
      check($sformatf("beat[%0d]", i), 32'(obs[i]), 32'(exp_beat));
    end
    check("gap_count", 32'(gaps.size()), (gap == 0) ? 32'd0 : 32'(nframes - 1));
    foreach (gaps[i]) check($sformatf("gap_len[%0d]", i), 32'(gaps[i]), 32'(gap));
    check("frames_sent", 32'(frames_sent), 32'(nframes));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; err_inject = 1'b0; tready = 1'b1;
    cfg_frame_len = '0; cfg_frame_count = '0; cfg_gap = '0; cfg_seed = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    rst_n = 1'b1;

    run(4, 2, 0, 'h10, 2, -1, -1, 0, 0);

    // stop while idle must not carry into the next run
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    run(3, 2, 5, 'hFE, 2, -1, -1, 0, 0);

    run(7, 3, 0, 'h5A, 3, -1, -1, 0, 1);
    run(7, 3, 0, 'h5A, 3, -1, -1, 0, 0);

    run(2, 0, 0, 'h20, 5, -1, 4, 0, 0);
    run(3, 1, 1, 'h40, 1, -1, -1, 0, 0);

    run(4, 3, 0, 'h80, 3, 1, -1, 0, 0);

    run(0, 5, 3, 'h77, 1, -1, -1, 1, 0);

    for (int r = 0; r < 3; r++) begin
      int l, c, g, s;
      l = $urandom_range(1, 6);
      c = $urandom_range(1, 4);
      g = $urandom_range(0, 3);
      s = $urandom_range(0, 255);
      run(l, c, g, s, c, -1, -1, 0, 1);
    end

    @(negedge clk);
    cfg_frame_len = 16'd8; cfg_frame_count = 16'd1; cfg_gap = 8'd0; cfg_seed = 8'h33;
    tready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("pre_rst_beat0", 32'(tdata), 32'h33);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_beat2", 32'({tvalid, tdata}), 32'h135);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames_sent", 32'(frames_sent), 32'd0);
    rst_n = 1'b1;
    run(8, 1, 0, 'h33, 1, -1, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
